// File: rtl/mcpu_mem_ltc_pkg.sv
// Shared LTC geometry and the line-reader FSM state encoding.
package mcpu_mem_ltc_pkg;

  localparam int LTC_DEPTH_BITS  = 9;
  localparam int LTC_WIDTH_BYTES = 32;
  localparam int LTC_LINE_BITS   = 2;
  localparam int LTC_LINE_BEATS  = 4;
  localparam int LTC_DATA_W      = LTC_WIDTH_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } ltc_rd_state_e;

endpackage

// File: rtl/mcpu_mem_ltc_skid2.sv
// Two-entry synchronous FIFO. Entry 0 is always the head, so the output is
// a plain register and a pop simply shifts entry 1 down.
module mcpu_mem_ltc_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;
  logic         push_ok;

  // Next entry contents and occupancy from push/pop.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'd2) || pop_ok);
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) e0_d = push_data;
        else                 e1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          e0_d = push_data;
        end else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head  = e0_q;
  assign count = count_q;

  // The issuing side must never push into a full FIFO without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == 2'd2)));

endmodule

// File: rtl/mcpu_mem_ltc_line_reader.sv
// Line reader for the LTC data array read port. Issues one line of reads
// into the 1-cycle-latency BRAM and streams the words out.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and valid/data hold while stalled.
module mcpu_mem_ltc_line_reader
  import mcpu_mem_ltc_pkg::*;
#(
  parameter int DEPTH_BITS  = LTC_DEPTH_BITS,
  parameter int WIDTH_BYTES = LTC_WIDTH_BYTES,
  parameter int LINE_BITS   = LTC_LINE_BITS,
  parameter int LINE_BEATS  = LTC_LINE_BEATS
) (
  input  logic                     clkrst_mem_clk,
  input  logic                     clkrst_mem_rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [DEPTH_BITS-1:0]    req_addr,
  output logic [DEPTH_BITS-1:0]    bram_addr1,
  output logic                     bram_re1,
  input  logic [WIDTH_BYTES*8-1:0] bram_rdata1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH_BYTES*8-1:0] out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int DW = WIDTH_BYTES * 8;

  ltc_rd_state_e               state_q, state_d;
  logic [DEPTH_BITS-1:LINE_BITS] base_q, base_d;
  logic [LINE_BITS:0]          issue_cnt_q, issue_cnt_d;
  logic                        inflight_q, inflight_d;
  logic                        inflight_last_q, inflight_last_d;

  logic [DW:0]                 fifo_head;
  logic [1:0]                  fifo_count;
  logic                        pop;
  logic                        issue;
  logic [2:0]                  occupancy;

  // Credit check and FSM next state. A read is issued only if the beat it
  // returns is guaranteed a FIFO slot, counting this cycle's pop.
  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    issue_cnt_d     = issue_cnt_q;
    pop             = out_valid && out_ready;
    occupancy       = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    issue           = (state_q == ST_READ) &&
                      (issue_cnt_q < (LINE_BITS+1)'(LINE_BEATS)) &&
                      (occupancy < 3'd2);
    inflight_d      = issue;
    inflight_last_d = issue && (issue_cnt_q[LINE_BITS-1:0] == '1);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          base_d      = req_addr[DEPTH_BITS-1:LINE_BITS];
          issue_cnt_d = '0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q[LINE_BITS-1:0] == '1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, line base, issue counter and in-flight tracking.
  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      issue_cnt_q     <= issue_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  mcpu_mem_ltc_skid2 #(.W(DW + 1)) u_skid (
    .clk       (clkrst_mem_clk),
    .rst       (clkrst_mem_rst),
    .push      (inflight_q),
    .push_data ({inflight_last_q, bram_rdata1}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bram_re1   = issue;
  assign bram_addr1 = {base_q, issue_cnt_q[LINE_BITS-1:0]};
  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = fifo_head[DW-1:0];
  assign out_last   = out_valid && fifo_head[DW];
  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mcpu_mem_ltc_line_reader.sv
// Bench for the LTC line reader: BRAM model, negedge monitor, and one task
// per scenario checked against expectations derived from the BRAM contents.
module tb_mcpu_mem_ltc_line_reader;

  localparam int DW = 256;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] bram_addr1;
  logic          bram_re1;
  logic [DW-1:0] bram_rdata1 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [1:0]    dbg_state;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [DW-1:0] mem [512];

  logic [AW-1:0] rd_addr_q [$];
  int            rd_cyc_q  [$];
  logic [DW:0]   got_q     [$];
  int            got_cyc_q [$];
  logic [DW:0]   exp_q     [$];

  logic          hold_chk = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  mcpu_mem_ltc_line_reader dut (
    .clkrst_mem_clk (clk),
    .clkrst_mem_rst (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .bram_addr1     (bram_addr1),
    .bram_re1       (bram_re1),
    .bram_rdata1    (bram_rdata1),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read BRAM model.
  always @(posedge clk) if (bram_re1) bram_rdata1 <= mem[bram_addr1];

  // Monitor: record issued reads, output handshakes, and stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (bram_re1) begin
        rd_addr_q.push_back(bram_addr1);
        rd_cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_data});
        got_cyc_q.push_back(cyc);
      end
    end
    if (hold_chk) begin
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          errors++;
          $display("FAIL hold_stable cyc=%0d valid=%b last=%b (required valid=1 last=%b, data unchanged)",
                   cyc, out_valid, out_last, prev_last);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  // Present a request until it is accepted; acc is the accepting cycle.
  task automatic issue_req(input logic [AW-1:0] addr, output int acc);
    int guard = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    while (!req_ready && guard < 500) begin
      step();
      guard++;
    end
    if (!req_ready) begin
      vectors++;
      errors++;
      $display("FAIL req_accept_timeout addr=%h", addr);
    end
    acc = cyc;
    step();
    req_valid = 1'b0;
  endtask

  // Wait for busy to drop; done is the first idle cycle.
  task automatic wait_idle(output int done);
    int guard = 0;
    while (busy && guard < 2000) begin
      step();
      guard++;
    end
    if (busy) begin
      vectors++;
      errors++;
      $display("FAIL idle_timeout busy=%b", busy);
    end
    done = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors += 6;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    if (bram_re1 !== 1'b0)  begin errors++; $display("FAIL rst_bram_re1 got=%b exp=0", bram_re1); end
    if (bram_addr1 !== '0)  begin errors++; $display("FAIL rst_bram_addr1 got=%h exp=0", bram_addr1); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int acc, done;
    clear_q();
    out_ready = 1'b1;
    issue_req(9'h024, acc);
    wait_idle(done);
    vectors += 3;
    if (done !== acc + 7) begin errors++; $display("FAIL basic_ready_cycle got=%0d exp=%0d", done - acc, 7); end
    if (rd_addr_q.size() != 4) begin errors++; $display("FAIL basic_read_count got=%0d exp=4", rd_addr_q.size()); end
    if (got_q.size() != 4) begin errors++; $display("FAIL basic_beat_count got=%0d exp=4", got_q.size()); end
    for (int k = 0; k < 4 && k < rd_addr_q.size() && k < got_q.size(); k++) begin
      vectors += 4;
      if (rd_addr_q[k] !== 9'(36 + k)) begin errors++; $display("FAIL basic_rd_addr k=%0d got=%h exp=%h", k, rd_addr_q[k], 36 + k); end
      if (rd_cyc_q[k] != acc + 1 + k) begin errors++; $display("FAIL basic_rd_cycle k=%0d got=%0d exp=%0d", k, rd_cyc_q[k] - acc, 1 + k); end
      if (got_q[k] !== {(k == 3), DW'(36 + k)}) begin errors++; $display("FAIL basic_beat k=%0d got=%h exp=%h", k, got_q[k], 36 + k); end
      if (got_cyc_q[k] != acc + 3 + k) begin errors++; $display("FAIL basic_beat_cycle k=%0d got=%0d exp=%0d", k, got_cyc_q[k] - acc, 3 + k); end
    end
  endtask

  task automatic test_alignment();
    int acc, done;
    clear_q();
    out_ready = 1'b1;
    issue_req(9'h1FE, acc);
    wait_idle(done);
    vectors += 2;
    if (rd_addr_q.size() != 4) begin errors++; $display("FAIL align_read_count got=%0d exp=4", rd_addr_q.size()); end
    if (got_q.size() != 4) begin errors++; $display("FAIL align_beat_count got=%0d exp=4", got_q.size()); end
    for (int k = 0; k < 4 && k < rd_addr_q.size() && k < got_q.size(); k++) begin
      vectors += 2;
      if (rd_addr_q[k] !== 9'(508 + k)) begin errors++; $display("FAIL align_rd_addr k=%0d got=%h exp=%h", k, rd_addr_q[k], 508 + k); end
      if (got_q[k] !== {(k == 3), mem[508 + k]}) begin errors++; $display("FAIL align_beat k=%0d got=%h", k, got_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    int acc, done;
    clear_q();
    out_ready = 1'b0;
    issue_req(9'h024, acc);
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      vectors += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid i=%0d got=%b exp=1", i, out_valid); end
      if (out_data !== mem[36]) begin errors++; $display("FAIL bp_head i=%0d got=%h exp=%h", i, out_data, mem[36]); end
      if (bram_re1 !== 1'b0) begin errors++; $display("FAIL bp_re_stall i=%0d got=%b exp=0", i, bram_re1); end
      step();
    end
    vectors++;
    if (rd_addr_q.size() != 2) begin errors++; $display("FAIL bp_reads_stalled got=%0d exp=2", rd_addr_q.size()); end
    out_ready = 1'b1;
    wait_idle(done);
    vectors += 2;
    if (rd_addr_q.size() != 4) begin errors++; $display("FAIL bp_read_count got=%0d exp=4", rd_addr_q.size()); end
    if (got_q.size() != 4) begin errors++; $display("FAIL bp_beat_count got=%0d exp=4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== {(k == 3), mem[36 + k]}) begin errors++; $display("FAIL bp_beat k=%0d got=%h", k, got_q[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int acc, done;
    out_ready = 1'b1;
    issue_req(9'h024, acc);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    if (bram_re1 !== 1'b0)  begin errors++; $display("FAIL midrst_re got=%b exp=0", bram_re1); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
    clear_q();
    issue_req(9'h040, acc);
    wait_idle(done);
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (got_q.size() != 4) begin errors++; $display("FAIL midrst_beat_count got=%0d exp=4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== {(k == 3), mem[64 + k]}) begin errors++; $display("FAIL midrst_beat k=%0d got=%h", k, got_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b, done, guard;
    int a = 9'h0A1;
    int b = 9'h133;
    clear_q();
    out_ready = 1'b1;
    issue_req(9'(a), acc_a);
    req_valid = 1'b1;
    req_addr  = 9'(b);
    guard = 0;
    while (!req_ready && guard < 200) begin step(); guard++; end
    acc_b = cyc;
    step();
    req_valid = 1'b0;
    wait_idle(done);
    vectors++;
    if (got_q.size() != 8) begin
      errors++;
      $display("FAIL b2b_beat_count got=%0d exp=8", got_q.size());
    end else begin
      vectors += 3;
      if (acc_b != got_cyc_q[3] + 1) begin errors++; $display("FAIL b2b_accept got=%0d exp=%0d", acc_b, got_cyc_q[3] + 1); end
      if (got_cyc_q[4] != acc_b + 3) begin errors++; $display("FAIL b2b_first_beat got=%0d exp=%0d", got_cyc_q[4], acc_b + 3); end
      if (got_cyc_q[7] != acc_b + 6) begin errors++; $display("FAIL b2b_last_beat got=%0d exp=%0d", got_cyc_q[7], acc_b + 6); end
      for (int k = 0; k < 8; k++) begin
        int base = (k < 4) ? (a & ~3) : (b & ~3);
        vectors++;
        if (got_q[k] !== {((k % 4) == 3), mem[base + (k % 4)]}) begin
          errors++;
          $display("FAIL b2b_beat k=%0d got=%h", k, got_q[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    int accepted = 0;
    int guard = 0;
    int base;
    int lasts = 0;
    clear_q();
    exp_q.delete();
    hold_chk = 1'b1;
    base = $urandom_range(0, 511);
    while (accepted < 200 && guard < 20000) begin
      req_valid = 1'b1;
      req_addr  = 9'(base);
      out_ready = 1'($urandom_range(0, 1));
      if (req_ready) begin
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), mem[(base & ~3) + k]});
        accepted++;
        base = $urandom_range(0, 511);
      end
      step();
      guard++;
    end
    req_valid = 1'b0;
    while (busy && guard < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    out_ready = 1'b1;
    step();
    hold_chk = 1'b0;
    vectors++;
    if (guard >= 20000 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_beat_count got=%0d exp=%0d guard=%0d", got_q.size(), exp_q.size(), guard);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i][DW]) lasts++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_beat i=%0d got_last=%b exp_last=%b got=%h exp=%h",
                 i, got_q[i][DW], exp_q[i][DW], got_q[i][31:0], exp_q[i][31:0]);
      end
    end
    vectors++;
    if (lasts != 200) begin errors++; $display("FAIL rand_last_count got=%0d exp=200", lasts); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = DW'(i);
    test_reset();
    test_basic();
    test_alignment();
    test_backpressure();
    test_reset_mid();
    for (int i = 0; i < 512; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
